// File: rtl/exe_unit_mc.sv
// exe_unit_mc: multi-cycle execute stage. It holds the ALU, the Val2 operand
// generator, the branch-target adder, an iterative shift-add multiplier
// (MUL/MLA) and the status register. Valid/ready handshakes sit on both sides.
// W is legal from 16 to 64; MUL_CYC must equal W.

// Operand-2 generator: memory offset, rotated imm8, or shifted register.
module exe_val2_gen #(
  parameter int W = 32
) (
  input  logic         mem_op_i,
  input  logic         imm_i,
  input  logic [11:0]  shift_operand_i,
  input  logic [W-1:0] val_rm_i,
  output logic [W-1:0] val2_o
);
  logic [W-1:0] imm8;
  int unsigned  imm_rot;
  int unsigned  sh_amt;
  int unsigned  ror_amt;

  // Select the operand source. A rotate is built as (x >> a) | (x << (W - a));
  // when a == 0 the left shift is by W and vanishes, leaving x unchanged.
  always_comb begin
    imm8    = W'(shift_operand_i[7:0]);
    imm_rot = 32'({shift_operand_i[11:8], 1'b0}) % W;
    sh_amt  = 32'(shift_operand_i[11:7]);
    ror_amt = sh_amt % W;
    val2_o  = val_rm_i;
    if (mem_op_i) begin
      val2_o = W'(shift_operand_i);
    end else if (imm_i) begin
      val2_o = (imm8 >> imm_rot) | (imm8 << (W - imm_rot));
    end else begin
      case (shift_operand_i[6:5])
        2'b00:   val2_o = val_rm_i << sh_amt;
        2'b01:   val2_o = val_rm_i >> sh_amt;
        2'b10:   val2_o = $signed(val_rm_i) >>> sh_amt;
        default: val2_o = (val_rm_i >> ror_amt) | (val_rm_i << (W - ror_amt));
      endcase
    end
  end
endmodule

module exe_unit_mc #(
  parameter int W       = 32,
  parameter int MUL_CYC = W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   exe_cmd,
  input  logic         mul_en,
  input  logic         acc_en,
  input  logic         s_en,
  input  logic         mem_r_en,
  input  logic         mem_w_en,
  input  logic         imm,
  input  logic [11:0]  shift_operand,
  input  logic [23:0]  signed_imm_24,
  input  logic [W-1:0] pc,
  input  logic [W-1:0] val_Rn,
  input  logic [W-1:0] val_Rm,
  input  logic [W-1:0] val_Rs,
  input  logic [3:0]   dest,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] alu_res,
  output logic [W-1:0] br_addr,
  output logic         out_mem_r_en,
  output logic         out_mem_w_en,
  output logic [3:0]   out_dest,
  output logic [3:0]   status
);
  localparam int CW = (MUL_CYC > 1) ? $clog2(MUL_CYC) : 1;

  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_MVN = 4'b1001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;

  typedef enum logic {S_IDLE, S_MUL} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  mcand_q, mcand_d;
  logic [W-1:0]  mplr_q, mplr_d;
  logic [W-1:0]  acc_q, acc_d;
  logic          mul_s_q, mul_s_d;
  logic          out_valid_q, out_valid_d;
  logic [W-1:0]  res_q, res_d;
  logic [W-1:0]  br_q, br_d;
  logic          mr_q, mr_d;
  logic          mw_q, mw_d;
  logic [3:0]    dest_q, dest_d;
  logic [3:0]    sr_q, sr_d;

  logic [W-1:0]  val2;
  logic [W-1:0]  opb;
  logic [W:0]    sum;
  logic          cin;
  logic          arith;
  logic [W-1:0]  alu_res_c;
  logic [3:0]    alu_sr_c;
  logic [W-1:0]  br_off;
  logic [W-1:0]  br_c;
  logic [W-1:0]  acc_step;
  logic          accept;
  logic          load;
  logic          mul_last;

  exe_val2_gen #(.W(W)) u_val2 (
    .mem_op_i        (mem_r_en | mem_w_en),
    .imm_i           (imm),
    .shift_operand_i (shift_operand),
    .val_rm_i        (val_Rm),
    .val2_o          (val2)
  );

  assign in_ready = (state_q == S_IDLE) && !flush && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  // Branch target: pc + ((sext(imm24) + 1) << 2), all arithmetic mod 2^W.
  always_comb begin
    br_off = W'($signed(signed_imm_24));
    br_c   = pc + ((br_off + W'(1)) << 2);
  end

  // ALU: one W+1 bit adder handles add/sub (subtract = add of ~Val2 with
  // carry in), so C is the ARM not-borrow for SUB/SBC. Logical ops keep C/V.
  always_comb begin
    opb       = val2;
    cin       = 1'b0;
    arith     = 1'b1;
    alu_res_c = '0;
    case (exe_cmd)
      CMD_ADD: begin opb = val2;  cin = 1'b0;    end
      CMD_ADC: begin opb = val2;  cin = sr_q[1]; end
      CMD_SUB: begin opb = ~val2; cin = 1'b1;    end
      CMD_SBC: begin opb = ~val2; cin = sr_q[1]; end
      default: arith = 1'b0;
    endcase
    sum = {1'b0, val_Rn} + {1'b0, opb} + {{W{1'b0}}, cin};
    case (exe_cmd)
      CMD_MOV: alu_res_c = val2;
      CMD_MVN: alu_res_c = ~val2;
      CMD_AND: alu_res_c = val_Rn & val2;
      CMD_ORR: alu_res_c = val_Rn | val2;
      CMD_EOR: alu_res_c = val_Rn ^ val2;
      CMD_ADD, CMD_ADC, CMD_SUB, CMD_SBC: alu_res_c = sum[W-1:0];
      default: alu_res_c = '0;
    endcase
    alu_sr_c[3] = alu_res_c[W-1];
    alu_sr_c[2] = (alu_res_c == '0);
    alu_sr_c[1] = arith ? sum[W] : sr_q[1];
    alu_sr_c[0] = arith ? ((val_Rn[W-1] == opb[W-1]) && (alu_res_c[W-1] != val_Rn[W-1]))
                        : sr_q[0];
  end

  // Next state for the FSM, multiplier datapath, output register and SR.
  // On a multiply accept the forwarded fields (dest, mem enables, br_addr)
  // are written straight into the output register: it is free for the whole
  // MUL phase because out_valid stays low until the product lands.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mcand_d     = mcand_q;
    mplr_d      = mplr_q;
    acc_d       = acc_q;
    mul_s_d     = mul_s_q;
    res_d       = res_q;
    br_d        = br_q;
    mr_d        = mr_q;
    mw_d        = mw_q;
    dest_d      = dest_q;
    sr_d        = sr_q;
    load        = 1'b0;
    mul_last    = (state_q == S_MUL) && (cnt_q == CW'(MUL_CYC - 1));
    acc_step    = acc_q + (mplr_q[0] ? mcand_q : '0);
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          br_d   = br_c;
          mr_d   = mem_r_en;
          mw_d   = mem_w_en;
          dest_d = dest;
          if (mul_en) begin
            state_d = S_MUL;
            cnt_d   = '0;
            mcand_d = val_Rm;
            mplr_d  = val_Rs;
            acc_d   = acc_en ? val_Rn : '0;
            mul_s_d = s_en;
          end else begin
            load  = 1'b1;
            res_d = alu_res_c;
            if (s_en) sr_d = alu_sr_c;
          end
        end
      end
      default: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          acc_d   = acc_step;
          mcand_d = mcand_q << 1;
          mplr_d  = mplr_q >> 1;
          cnt_d   = cnt_q + CW'(1);
          if (mul_last) begin
            state_d = S_IDLE;
            load    = 1'b1;
            res_d   = acc_step;
            if (mul_s_q) sr_d = {acc_step[W-1], (acc_step == '0), sr_q[1:0]};
          end
        end
      end
    endcase
    if (flush)          out_valid_d = 1'b0;
    else if (load)      out_valid_d = 1'b1;
    else if (out_ready) out_valid_d = 1'b0;
    else                out_valid_d = out_valid_q;
  end

  // State, datapath and output registers; async active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      mcand_q     <= '0;
      mplr_q      <= '0;
      acc_q       <= '0;
      mul_s_q     <= 1'b0;
      out_valid_q <= 1'b0;
      res_q       <= '0;
      br_q        <= '0;
      mr_q        <= 1'b0;
      mw_q        <= 1'b0;
      dest_q      <= '0;
      sr_q        <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mcand_q     <= mcand_d;
      mplr_q      <= mplr_d;
      acc_q       <= acc_d;
      mul_s_q     <= mul_s_d;
      out_valid_q <= out_valid_d;
      res_q       <= res_d;
      br_q        <= br_d;
      mr_q        <= mr_d;
      mw_q        <= mw_d;
      dest_q      <= dest_d;
      sr_q        <= sr_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign alu_res      = res_q;
  assign br_addr      = br_q;
  assign out_mem_r_en = mr_q;
  assign out_mem_w_en = mw_q;
  assign out_dest     = dest_q;
  assign status       = sr_q;
endmodule

// File: doc/exe_unit_mc.md
# exe_unit_mc

Parametrised, multi-cycle successor to the single-cycle execute stage. It contains the ALU, the Val2 operand generator, a branch-target adder, and an iterative shift-add multiplier supporting MUL and MLA. It also holds the architectural status register internally. It sits between the ID/EXE and EXE/MEM boundaries, owns the EXE/MEM output register, and uses valid/ready handshakes on both sides so a multiply can stall the front end.

## Interface
- W, 32: datapath width; legal 16..64.
- MUL_CYC, W: multiplier iterations, one bit per cycle; must equal W.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous kill of in-flight work (branch taken).
- in_valid  in  1  operation offered.
- in_ready  out  1  unit accepts the operation this cycle.
- exe_cmd  in  4  ALU command in the existing encoding: MOV 0001, MVN 1001, ADD 0010, ADC 0011, SUB 0100, SBC 0101, AND 0110, ORR 0111, EOR 1000.
- mul_en, acc_en  in  1 each  MUL; MLA when both are 1.
- s_en  in  1  update status from this operation.
- mem_r_en, mem_w_en  in  1 each  memory op; forwarded to the output.
- imm  in  1  immediate Val2.
- shift_operand  in  12  ARM operand-2 field.
- signed_imm_24  in  24  branch offset.
- pc, val_Rn, val_Rm, val_Rs  in  W each  PC+4 and operands.
- dest  in  4  destination register; forwarded to the output.
- out_valid  out  1  output register holds a result.
- out_ready  in  1  MEM stage accepts it.
- alu_res, br_addr  out  W each  registered result and branch target.
- out_mem_r_en, out_mem_w_en  out  1 each  registered copies of the memory enables.
- out_dest  out  4  registered copy of dest.
- status  out  4  SR as {N,Z,C,V}, registered.

## Operation
- FSM states:
  - IDLE: no multiply in progress.
  - MUL: shift-add loop running.
- in_ready = (state==IDLE) && !flush && (!out_valid || out_ready). Accept = in_valid && in_ready.
- Val2 generation:
  - Memory op: zero-extended shift_operand[11:0].
  - imm=1: zero-extended imm8 = shift_operand[7:0], rotated right by 2*shift_operand[11:8] mod W.
  - Otherwise: val_Rm shifted by shift_operand[11:7] with type [6:5] = LSL/LSR/ASR/ROR; a shift of 0 is a pass-through.
- ALU op (mul_en=0), computed at accept:
  - Inputs are val_Rn and Val2; carry_in = SR.C.
  - N = res[W-1]; Z = (res==0).
  - C is the carry out of the W-bit add; for subtract it is the ARM not-borrow.
  - V is signed overflow for add/sub; C and V are unchanged for logical ops.
- MUL/MLA:
  - At accept, latch multiplicand = val_Rm, multiplier = val_Rs, and acc = acc_en ? val_Rn : 0. Go to MUL.
  - Each cycle: if multiplier[0], acc += multiplicand; then multiplicand <<= 1 and multiplier >>= 1.
  - After MUL_CYC cycles, load the output register with acc mod 2^W and return to IDLE.
  - Status from a multiply updates N and Z only; C and V are preserved.
- br_addr = pc + ((sign-extend(signed_imm_24) + 1) << 2), truncated to W; registered with every result.
- SR is written at the edge that loads the output register, and only when s_en=1. A subsequent operation therefore always sees the updated carry.
- flush:
  - Clears out_valid and aborts a MUL (state goes to IDLE, SR untouched).
  - A flushed multiply never writes SR.
  - An ALU result already in the output register has committed its SR write; that write is not undone.
- Reset (rst=0, asynchronous, at any time including mid-MUL):
  - state=IDLE; out_valid=0; SR=0.
  - alu_res, br_addr, and all forwarded outputs = 0.

## Timing
- ALU op: accept at edge k; out_valid=1 after edge k. Latency 1, throughput 1 per cycle while out_ready=1.
- MUL/MLA: accept at edge k; in_ready=0 for MUL_CYC cycles; out_valid after edge k+MUL_CYC. Latency W+1 cycles from the accept cycle.
- Output register holds stable while out_valid && !out_ready.
- A new load is allowed in the same cycle the old result is consumed.
- flush in the same cycle as in_valid: the operation is not accepted.
- flush has priority over load.

## Test plan
- Reset, then ADD with val_Rn=5, imm=1, shift_operand=0x003 -> after 1 cycle alu_res=8, out_valid=1, status=0000.
- SUB with s_en=1, val_Rn=7, Val2=7 -> alu_res=0, status=0110 (Z, C). A following ADC 1+1 -> 3.
- MUL with W=32, val_Rm=7, val_Rs=6 -> in_ready low for 32 cycles, then alu_res=42. Repeat with MLA and val_Rn=10 -> 52; with s_en=1, C and V are unchanged.
- out_ready held 0 for 5 cycles with out_valid=1 -> alu_res stable and in_ready=0. Release -> next operation accepted in the same cycle.
- flush asserted mid-MUL at cycle 10 -> out_valid stays 0, SR is unchanged, and in_ready returns the next cycle. Reset pulsed mid-MUL -> all outputs 0 immediately.
- Branch with pc=100 and signed_imm_24=0xFFFFFE -> br_addr=96; with signed_imm_24=0x000003 -> br_addr=116.
